// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer: exception codes, CSR
// addresses, mcause values, mstatus bit positions and FSM states (TRAP_MTVAL_EN adds W_MTVAL).
package trap_sequencer_pkg;

  localparam int EXC_STATUS_WIDTH = 3;

  typedef enum logic [EXC_STATUS_WIDTH-1:0] {
    EXC_IDLE    = 3'd0,
    EXC_ECALL   = 3'd1,
    EXC_EBREAK  = 3'd2,
    EXC_ILLEGAL = 3'd3,
    EXC_MRET    = 3'd4
  } exc_status_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] MCAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] MCAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL   = 32'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_DRAIN         = 3'd1,
    ST_W_MEPC        = 3'd2,
    ST_W_MCAUSE      = 3'd3,
    ST_W_MSTATUS     = 3'd4,
    ST_W_MSTATUS_RET = 3'd5,
    ST_JUMP          = 3'd6
`ifdef TRAP_MTVAL_EN
    , ST_W_MTVAL     = 3'd7
`endif
  } state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, record machine mode.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE] = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle of ID-stage, interrupt, CSR and redirect signals around the trap sequencer.
interface trap_sequencer_if;
  import trap_sequencer_pkg::*;

  logic [EXC_STATUS_WIDTH-1:0] exc_status_i;
  logic [31:0] inst_addr_i;
  logic        id_valid_i;
  logic        br_taken_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic [31:0] csr_mstatus_i;
  logic [31:0] csr_mie_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_flag_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport slave (
    input  exc_status_i, inst_addr_i, id_valid_i, br_taken_i,
    input  irq_timer_i, irq_ext_i,
    input  csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o,
    output hold_flag_o, redirect_valid_o, redirect_pc_o, busy_o
  );

  modport master (
    output exc_status_i, inst_addr_i, id_valid_i, br_taken_i,
    output irq_timer_i, irq_ext_i,
    output csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o,
    input  hold_flag_o, redirect_valid_o, redirect_pc_o, busy_o
  );

endinterface

// File: rtl/trap_arbiter.sv
// Combinational trap arbitration: external irq > timer irq > exception > MRET,
// all gated by a valid, non-cancelled instruction in ID.
module trap_arbiter
  import trap_sequencer_pkg::*;
(
  input  logic [EXC_STATUS_WIDTH-1:0] exc_status,
  input  logic                        id_valid,
  input  logic                        br_taken,
  input  logic                        irq_timer,
  input  logic                        irq_ext,
  input  logic                        mstatus_mie,
  input  logic                        mie_mtie,
  input  logic                        mie_meie,
  output logic                        trap_req,
  output logic [31:0]                 cause,
  output logic                        is_int,
  output logic                        is_mret
);

  logic gate;
  logic int_ext;
  logic int_tmr;

  assign gate    = id_valid & ~br_taken;
  assign int_ext = irq_ext & mstatus_mie & mie_meie;
  assign int_tmr = irq_timer & mstatus_mie & mie_mtie;

  always_comb begin
    trap_req = 1'b0;
    cause    = '0;
    is_int   = 1'b0;
    is_mret  = 1'b0;
    if (gate) begin
      if (int_ext) begin
        trap_req = 1'b1;
        cause    = MCAUSE_EXT;
        is_int   = 1'b1;
      end else if (int_tmr) begin
        trap_req = 1'b1;
        cause    = MCAUSE_TIMER;
        is_int   = 1'b1;
      end else begin
        case (exc_status_e'(exc_status))
          EXC_ILLEGAL: begin
            trap_req = 1'b1;
            cause    = MCAUSE_ILLEGAL;
          end
          EXC_ECALL: begin
            trap_req = 1'b1;
            cause    = MCAUSE_ECALL;
          end
          EXC_EBREAK: begin
            trap_req = 1'b1;
            cause    = MCAUSE_EBREAK;
          end
          EXC_MRET: begin
            trap_req = 1'b1;
            is_mret  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: drains the pipeline, writes trap CSRs one per cycle,
// then issues a single PC redirect. Define TRAP_MTVAL_EN to also write mtval.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  trap_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] DRAIN_LAST =
    (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      cause_reg;
  logic             is_int_reg;
  logic             is_mret_reg;

  logic        arb_req;
  logic [31:0] arb_cause;
  logic        arb_is_int;
  logic        arb_is_mret;
  logic        trap_req;
  logic        busy;

  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  trap_arbiter u_arbiter (
    .exc_status  (bus.exc_status_i),
    .id_valid    (bus.id_valid_i),
    .br_taken    (bus.br_taken_i),
    .irq_timer   (bus.irq_timer_i),
    .irq_ext     (bus.irq_ext_i),
    .mstatus_mie (bus.csr_mstatus_i[MSTATUS_MIE]),
    .mie_mtie    (bus.csr_mie_i[MIE_MTIE]),
    .mie_meie    (bus.csr_mie_i[MIE_MEIE]),
    .trap_req    (arb_req),
    .cause       (arb_cause),
    .is_int      (arb_is_int),
    .is_mret     (arb_is_mret)
  );

  logic unused_mie_bits;
  assign unused_mie_bits = ^{bus.csr_mie_i[31:12], bus.csr_mie_i[10:8], bus.csr_mie_i[6:0]};

  // Arbitration is only honoured in IDLE; mid-sequence input changes are ignored.
  assign busy     = (state_reg != ST_IDLE);
  assign trap_req = arb_req & ~busy;

  assign trap_base   = {bus.csr_mtvec_i[31:2], 2'b00};
  assign trap_target = ((bus.csr_mtvec_i[1:0] == 2'b01) && is_int_reg)
                       ? trap_base + {26'd0, cause_reg[3:0], 2'b00}
                       : trap_base;

`ifdef TRAP_MTVAL_EN
  logic [31:0] mtval_data;
  assign mtval_data = (!is_int_reg && ((cause_reg == MCAUSE_ILLEGAL) ||
                                       (cause_reg == MCAUSE_EBREAK))) ? pc_reg : 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pc_reg      <= '0;
      cause_reg   <= '0;
      is_int_reg  <= 1'b0;
      is_mret_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (trap_req) begin
        cnt_reg     <= '0;
        pc_reg      <= bus.inst_addr_i;
        cause_reg   <= arb_cause;
        is_int_reg  <= arb_is_int;
        is_mret_reg <= arb_is_mret;
      end else if (state_reg == ST_DRAIN) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (trap_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_reg == DRAIN_LAST) state_next = is_mret_reg ? ST_W_MSTATUS_RET : ST_W_MEPC;
      end
      ST_W_MEPC: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MEPC;
        csr_wdata  = pc_reg;
        state_next = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_reg;
`ifdef TRAP_MTVAL_EN
        state_next = ST_W_MTVAL;
`else
        state_next = ST_W_MSTATUS;
`endif
      end
`ifdef TRAP_MTVAL_EN
      ST_W_MTVAL: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MTVAL;
        csr_wdata  = mtval_data;
        state_next = ST_W_MSTATUS;
      end
`endif
      ST_W_MSTATUS: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MSTATUS;
        csr_wdata  = mstatus_on_trap(bus.csr_mstatus_i);
        state_next = ST_JUMP;
      end
      ST_W_MSTATUS_RET: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MSTATUS;
        csr_wdata  = mstatus_on_mret(bus.csr_mstatus_i);
        state_next = ST_JUMP;
      end
      ST_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = is_mret_reg ? bus.csr_mepc_i : trap_target;
        state_next     = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.csr_we_o         = csr_we;
  assign bus.csr_waddr_o      = csr_waddr;
  assign bus.csr_wdata_o      = csr_wdata;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;
  assign bus.busy_o           = busy;
  assign bus.hold_flag_o      = trap_req | busy;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap/interrupt/MRET sequences, gating and mid-sequence reset.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  trap_sequencer_if bus ();

  trap_sequencer #(.DRAIN_CYCLES(3), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [11:0] addr,
                         input logic [31:0] data, input logic redir, input logic [31:0] rpc,
                         input logic busy, input logic hold);
    chk({tag, ".we"},     {31'd0, bus.csr_we_o},         {31'd0, we});
    chk({tag, ".waddr"},  {20'd0, bus.csr_waddr_o},      {20'd0, addr});
    chk({tag, ".wdata"},  bus.csr_wdata_o,               data);
    chk({tag, ".redir"},  {31'd0, bus.redirect_valid_o}, {31'd0, redir});
    chk({tag, ".rpc"},    bus.redirect_pc_o,             rpc);
    chk({tag, ".busy"},   {31'd0, bus.busy_o},           {31'd0, busy});
    chk({tag, ".hold"},   {31'd0, bus.hold_flag_o},      {31'd0, hold});
  endtask

  task automatic idle_inputs;
    bus.exc_status_i = EXC_IDLE;
    bus.irq_timer_i  = 1'b0;
    bus.irq_ext_i    = 1'b0;
    bus.id_valid_i   = 1'b1;
    bus.br_taken_i   = 1'b0;
  endtask

  // Called one cycle before the capture edge; walks drain, CSR writes, redirect, return to IDLE.
  task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] mst, input logic [31:0] mtval, input logic [31:0] rpc);
    for (int i = 0; i < 3; i++) begin
      tick;
      if (i == 0) idle_inputs;
      chk_out({tag, ".drain"}, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    tick;
    chk_out({tag, ".mepc"}, 1'b1, CSR_MEPC, pc, 1'b0, 32'h0, 1'b1, 1'b1);
    tick;
    chk_out({tag, ".mcause"}, 1'b1, CSR_MCAUSE, cause, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef TRAP_MTVAL_EN
    tick;
    chk_out({tag, ".mtval"}, 1'b1, CSR_MTVAL, mtval, 1'b0, 32'h0, 1'b1, 1'b1);
`endif
    tick;
    chk_out({tag, ".mstatus"}, 1'b1, CSR_MSTATUS, mst, 1'b0, 32'h0, 1'b1, 1'b1);
    tick;
    chk_out({tag, ".jump"}, 1'b0, 12'h0, 32'h0, 1'b1, rpc, 1'b1, 1'b1);
    tick;
    chk_out({tag, ".idle"}, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    $display("txn %s pc=%h cause=%h mstatus=%h mtval=%h redirect=%h", tag, pc, cause, mst, mtval, rpc);
  endtask

  initial begin
    bus.exc_status_i  = EXC_IDLE;
    bus.inst_addr_i   = 32'h0;
    bus.id_valid_i    = 1'b0;
    bus.br_taken_i    = 1'b0;
    bus.irq_timer_i   = 1'b0;
    bus.irq_ext_i     = 1'b0;
    bus.csr_mstatus_i = 32'h0;
    bus.csr_mie_i     = 32'h0;
    bus.csr_mtvec_i   = 32'h0;
    bus.csr_mepc_i    = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_out("reset", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk_out("post_reset", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // ECALL at 0x100, direct mtvec
    bus.csr_mtvec_i   = 32'h200;
    bus.csr_mstatus_i = 32'h8;
    bus.inst_addr_i   = 32'h100;
    bus.id_valid_i    = 1'b1;
    bus.exc_status_i  = EXC_ECALL;
    #1;
    chk_out("ecall.capture", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    run_trap("ecall", 32'h100, 32'd11, 32'h1880, 32'h0, 32'h200);

    // External irq beats ILLEGAL, vectored mtvec
    bus.csr_mie_i     = 32'h880;
    bus.csr_mtvec_i   = 32'h301;
    bus.inst_addr_i   = 32'h400;
    bus.exc_status_i  = EXC_ILLEGAL;
    bus.irq_ext_i     = 1'b1;
    #1;
    chk_out("ext.capture", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    run_trap("ext_irq", 32'h400, 32'h8000_000B, 32'h1880, 32'h0, 32'h32C);

    // Timer irq masked by mstatus.MIE, then enabled
    bus.csr_mtvec_i   = 32'h200;
    bus.csr_mstatus_i = 32'h0;
    bus.inst_addr_i   = 32'h500;
    bus.irq_timer_i   = 1'b1;
    #1;
    chk_out("tmr.masked", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick;
    chk_out("tmr.masked_next", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.csr_mstatus_i = 32'h8;
    #1;
    chk_out("tmr.capture", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    run_trap("timer_irq", 32'h500, 32'h8000_0007, 32'h1880, 32'h0, 32'h200);

    // MRET: single mstatus write then redirect to mepc
    bus.csr_mstatus_i = 32'h1880;
    bus.csr_mepc_i    = 32'h104;
    bus.inst_addr_i   = 32'h600;
    bus.exc_status_i  = EXC_MRET;
    #1;
    chk_out("mret.capture", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      if (i == 0) idle_inputs;
      chk_out("mret.drain", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    tick;
    chk_out("mret.mstatus", 1'b1, CSR_MSTATUS, 32'h1888, 1'b0, 32'h0, 1'b1, 1'b1);
    tick;
    chk_out("mret.jump", 1'b0, 12'h0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b1);
    tick;
    chk_out("mret.idle", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    $display("txn mret mstatus=00001888 redirect=00000104");

    // Gating: cancelled or invalid instruction
    bus.exc_status_i = EXC_ECALL;
    bus.br_taken_i   = 1'b1;
    #1;
    chk_out("gate.br_taken", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick;
    chk_out("gate.br_taken_next", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.br_taken_i = 1'b0;
    bus.id_valid_i = 1'b0;
    #1;
    chk_out("gate.invalid", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick;
    chk_out("gate.invalid_next", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    $display("txn gated ecall ignored");

    // Reset asserted during W_MCAUSE
    bus.csr_mstatus_i = 32'h8;
    bus.csr_mtvec_i   = 32'h200;
    bus.inst_addr_i   = 32'h700;
    bus.id_valid_i    = 1'b1;
    bus.exc_status_i  = EXC_ECALL;
    #1;
    tick;
    idle_inputs;
    tick;
    tick;
    tick;
    chk_out("rst.mepc", 1'b1, CSR_MEPC, 32'h700, 1'b0, 32'h0, 1'b1, 1'b1);
    tick;
    chk_out("rst.mcause", 1'b1, CSR_MCAUSE, 32'd11, 1'b0, 32'h0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_out("rst.abort", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("rst.after.we", {31'd0, bus.csr_we_o}, 32'd0);
      chk("rst.after.redir", {31'd0, bus.redirect_valid_o}, 32'd0);
      chk("rst.after.busy", {31'd0, bus.busy_o}, 32'd0);
    end
    $display("txn reset abort during mcause write");

    // ILLEGAL at 0x40: exceptions are never vectored
    bus.csr_mstatus_i = 32'h0;
    bus.csr_mtvec_i   = 32'h301;
    bus.inst_addr_i   = 32'h40;
    bus.exc_status_i  = EXC_ILLEGAL;
    #1;
    chk_out("illegal.capture", 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    run_trap("illegal", 32'h40, 32'd2, 32'h1800, 32'h40, 32'h300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
